// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the single-cycle integer ALU.
// Age-ordered collapsing queue (entry 0 = oldest). Each entry waits until its
// operands are ready, then issues the oldest ready op into a registered bundle.
// Optional build macro: RS_CDB_BYPASS_EN. When defined, a source that matches
// the current CDB broadcast counts as ready for this cycle's select, and
// cdb_val is forwarded straight into the issue registers.
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [3:0]                disp_ctrl,
  input  logic                      disp_alusrc,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [TAG_W-1:0]          disp_rd_tag,
  input  logic [TAG_W-1:0]          disp_rs1_tag,
  input  logic [TAG_W-1:0]          disp_rs2_tag,
  input  logic                      disp_rs1_rdy,
  input  logic                      disp_rs2_rdy,
  input  logic [DATA_W-1:0]         disp_rs1_val,
  input  logic [DATA_W-1:0]         disp_rs2_val,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_val,
  output logic                      issue_valid,
  output logic [3:0]                issue_ctrl,
  output logic                      issue_alusrc,
  output logic [DATA_W-1:0]         issue_rs1,
  output logic [DATA_W-1:0]         issue_rs2,
  output logic [DATA_W-1:0]         issue_imm,
  output logic [TAG_W-1:0]          issue_rd_tag,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  typedef struct packed {
    logic [3:0]        ctrl;
    logic              alusrc;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1_val;
    logic [TAG_W-1:0]  rs2_tag;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2_val;
  } entry_t;

  // Registered state
  entry_t             entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [OCC_W-1:0]   occ_q;
  logic               issue_valid_q;
  logic [3:0]         issue_ctrl_q;
  logic               issue_alusrc_q;
  logic [DATA_W-1:0]  issue_rs1_q;
  logic [DATA_W-1:0]  issue_rs2_q;
  logic [DATA_W-1:0]  issue_imm_q;
  logic [TAG_W-1:0]   issue_rd_tag_q;

  // Next-state / combinational
  entry_t             entry_w [DEPTH];   // entries after this cycle's wakeup
  entry_t             entry_c [DEPTH];   // after collapse of the issued slot
  entry_t             entry_d [DEPTH];   // after dispatch write
  logic [DEPTH-1:0]   valid_c;
  logic [DEPTH-1:0]   valid_d;
  logic [DEPTH-1:0]   src1_ok;
  logic [DEPTH-1:0]   src2_ok;
  logic [DEPTH-1:0]   elig;
  logic [IDX_W-1:0]   sel_idx;
  logic               issue_fire;
  logic               disp_accept;
  logic [OCC_W-1:0]   wr_pos;
  logic [OCC_W-1:0]   occ_d;
  entry_t             new_entry;

  // Latch a broadcast value into any unready source whose tag matches.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [TAG_W-1:0] t,
                                  input logic [DATA_W-1:0] d);
    entry_t r;
    r = e;
    if (v && !e.rs1_rdy && (e.rs1_tag == t)) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = d;
    end
    if (v && !e.rs2_rdy && (e.rs2_tag == t)) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = d;
    end
    return r;
  endfunction

  // Readiness only depends on registered occupancy, so a full station that
  // issues this cycle still refuses a dispatch.
  assign disp_ready  = (occ_q < OCC_W'(DEPTH));
  assign disp_accept = disp_valid && disp_ready;
  // Valid entries are contiguous from slot 0, so the youngest free slot after
  // a same-cycle collapse is simply occupancy minus the issue.
  assign wr_pos      = occ_q - {{IDX_W{1'b0}}, issue_fire};
  assign occ_d       = occ_q + {{IDX_W{1'b0}}, disp_accept} - {{IDX_W{1'b0}}, issue_fire};

  // Build the incoming entry, capturing a same-cycle CDB broadcast.
  always_comb begin
    new_entry         = '0;
    new_entry.ctrl    = disp_ctrl;
    new_entry.alusrc  = disp_alusrc;
    new_entry.imm     = disp_imm;
    new_entry.rd_tag  = disp_rd_tag;
    new_entry.rs1_tag = disp_rs1_tag;
    new_entry.rs2_tag = disp_rs2_tag;
    new_entry.rs1_rdy = disp_rs1_rdy | (cdb_valid && (disp_rs1_tag == cdb_tag));
    new_entry.rs2_rdy = disp_rs2_rdy | (cdb_valid && (disp_rs2_tag == cdb_tag));
    new_entry.rs1_val = disp_rs1_rdy ? disp_rs1_val : cdb_val;
    new_entry.rs2_val = disp_rs2_rdy ? disp_rs2_val : cdb_val;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign entry_w[gi] = wake(entry_q[gi], cdb_valid, cdb_tag, cdb_val);

`ifdef RS_CDB_BYPASS_EN
      // The woken copy already reflects the current broadcast.
      assign src1_ok[gi] = entry_w[gi].rs1_rdy;
      assign src2_ok[gi] = entry_w[gi].rs2_rdy | entry_q[gi].alusrc;
`else
      assign src1_ok[gi] = entry_q[gi].rs1_rdy;
      assign src2_ok[gi] = entry_q[gi].rs2_rdy | entry_q[gi].alusrc;
`endif
      // rs2 is still woken when alusrc=1; it just does not gate eligibility.
      assign elig[gi] = valid_q[gi] & src1_ok[gi] & src2_ok[gi];

      if (gi < DEPTH - 1) begin : g_shift
        assign entry_c[gi] = (issue_fire && (gi >= int'(sel_idx))) ? entry_w[gi+1] : entry_w[gi];
        assign valid_c[gi] = (issue_fire && (gi >= int'(sel_idx))) ? valid_q[gi+1] : valid_q[gi];
      end else begin : g_top
        // Top slot always empties when anything issues.
        assign entry_c[gi] = entry_w[gi];
        assign valid_c[gi] = issue_fire ? 1'b0 : valid_q[gi];
      end

      assign entry_d[gi] = (disp_accept && (wr_pos == OCC_W'(gi))) ? new_entry : entry_c[gi];
      assign valid_d[gi] = valid_c[gi] | (disp_accept && (wr_pos == OCC_W'(gi)));
    end
  endgenerate

  // Oldest-first select: lowest eligible index wins.
  always_comb begin
    sel_idx    = '0;
    issue_fire = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_idx    = IDX_W'(i);
        issue_fire = 1'b1;
      end
    end
  end

  // Entry payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  // Control state and issue registers; rst clears everything, flush only squashes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      occ_q          <= '0;
      issue_valid_q  <= 1'b0;
      issue_ctrl_q   <= '0;
      issue_alusrc_q <= 1'b0;
      issue_rs1_q    <= '0;
      issue_rs2_q    <= '0;
      issue_imm_q    <= '0;
      issue_rd_tag_q <= '0;
    end else if (flush) begin
      valid_q       <= '0;
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      occ_q         <= occ_d;
      issue_valid_q <= issue_fire;
      if (issue_fire) begin
        // Operands come from the woken copy, which carries cdb_val when bypassing.
        issue_ctrl_q   <= entry_w[sel_idx].ctrl;
        issue_alusrc_q <= entry_w[sel_idx].alusrc;
        issue_rs1_q    <= entry_w[sel_idx].rs1_val;
        issue_rs2_q    <= entry_w[sel_idx].rs2_val;
        issue_imm_q    <= entry_w[sel_idx].imm;
        issue_rd_tag_q <= entry_w[sel_idx].rd_tag;
      end
    end
  end

  // Invariants: bounded, contiguous occupancy and rs1 ready on every issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_q <= OCC_W'(DEPTH));
      assert ($countones(valid_q) == int'(occ_q));
      if (issue_fire) begin
        assert (entry_w[sel_idx].rs1_rdy);
      end
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_ctrl   = issue_ctrl_q;
  assign issue_alusrc = issue_alusrc_q;
  assign issue_rs1    = issue_rs1_q;
  assign issue_rs2    = issue_rs2_q;
  assign issue_imm    = issue_imm_q;
  assign issue_rd_tag = issue_rd_tag_q;
  assign occupancy    = occ_q;

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that sits directly upstream of the single-cycle integer ALU in the out-of-order core.
- Accepts dispatched ALU ops from rename/dispatch and holds them until both source operands are available.
- Operands are captured either at dispatch or from the common data bus (CDB).
- Each cycle, issues the oldest ready entry to the ALU as a registered opcode/operand bundle.

Parameters:
- DEPTH, 8, number of entries (power of 2, >= 2).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous squash of all entries and the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept a dispatch this cycle.
- disp_ctrl  in  4  ALU control code (and=0000, or=0001, add=0010, xor=0011, sub=0110, sra=1110).
- disp_alusrc  in  1  1 = use imm as operand B.
- disp_imm  in  DATA_W  immediate.
- disp_rd_tag  in  TAG_W  destination tag.
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  source tags.
- disp_rs1_rdy, disp_rs2_rdy  in  1  source value already valid.
- disp_rs1_val, disp_rs2_val  in  DATA_W  source values, meaningful when the matching rdy is 1.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_val  in  DATA_W  broadcast value.
- issue_valid  out  1  issue bundle valid.
- issue_ctrl  out  4  ALU control.
- issue_alusrc  out  1  operand-B select.
- issue_rs1, issue_rs2, issue_imm  out  DATA_W  operand values.
- issue_rd_tag  out  TAG_W  destination tag.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset/flush:
  - On rst or flush at a clock edge: all entries invalid, occupancy=0, issue_valid=0.
  - All issue_* data outputs cleared to 0 on rst only; flush leaves them unchanged.
  - rst/flush take priority over a dispatch or issue in the same cycle.
- Storage:
  - Age-ordered collapsing queue; entry 0 is the oldest.
  - Per entry: ctrl, alusrc, imm, rd_tag, and for each source {tag, rdy, val}.
- Dispatch:
  - Accepted when disp_valid && disp_ready.
  - disp_ready = (occupancy < DEPTH), computed from registered occupancy only. A full station is not ready even if it issues in the same cycle.
  - The entry is written at the youngest position after any same-cycle collapse.
- Dispatch-time capture:
  - Applies to any source with rdy=0 whose tag equals cdb_tag while cdb_valid=1 in the dispatch cycle.
  - That source is stored as rdy=1 with val=cdb_val.
- Wakeup:
  - Every cycle, each valid entry with an unready source whose tag matches a valid CDB broadcast latches cdb_val and sets rdy at the clock edge.
  - rs2 is woken even when alusrc=1.
- Select:
  - Eligible entry: valid, rs1 rdy, and (rs2 rdy or alusrc=1), evaluated on registered state.
  - The lowest-index eligible entry is chosen.
  - At the edge, the chosen entry's fields load the issue registers, issue_valid=1, and the entry is removed; younger entries shift down one slot.
  - The ALU never stalls, so there is no issue backpressure.
  - With no eligible entry, issue_valid=0 next cycle and issue_* data holds its last value.
- Latency:
  - An op dispatched with both sources ready at edge E0 appears on issue_* after edge E1.
  - A source woken at edge W makes the entry eligible after W, so it issues after W+1.
- Simultaneous events:
  - Dispatch, wakeup and issue can all occur in one cycle.
  - occupancy next = occupancy + accepted dispatch − issue.
- Invariant (asserted): occupancy <= DEPTH; issue_valid implies issue_rs1 came from a ready source.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined:
  - A source matching the current cycle's CDB broadcast counts as ready for this cycle's select.
  - cdb_val is muxed into issue_rs1/issue_rs2 directly, which cuts wakeup-to-issue by one cycle (issues after edge W).
  - Dispatch-time capture is unchanged; a newly dispatched entry is still not selectable in its dispatch cycle.
- Undefined: the timing in Behaviour applies.

Test Plan:
- Reset then dispatch add, rs1=5 rdy, rs2=7 rdy, rd_tag=3 at E0 -> issue_valid=1 after E1 with ctrl=0010, rs1=5, rs2=7, rd_tag=3; occupancy back to 0.
- Dispatch sub, rs1 tag=9 unready, rs2=1 rdy; CDB tag=9 val=20 two cycles later at edge W -> issue after W+1 with rs1=20 (after W when RS_CDB_BYPASS_EN is defined).
- Fill 8 entries all waiting on tag 4 -> disp_ready=0, occupancy=8; CDB tag=4 val=11 -> entries issue one per cycle in dispatch order, disp_ready=1 after the first issue.
- Dispatch with rs2 unready and alusrc=1, imm=0xFFFFFFF0 -> issues immediately with issue_imm=0xFFFFFFF0, not blocked by rs2.
- Dispatch in the same cycle that CDB broadcasts the matching rs1 tag=12 val=0x80000000 -> entry captures the value and issues after the next edge with rs1=0x80000000.
- 5 entries valid, assert flush together with disp_valid -> next cycle occupancy=0, issue_valid=0, dispatched op discarded.
